// File: rtl/fetch_pkg.sv
// Shared types and defaults for the instruction-fetch front end.
package fetch_pkg;
  localparam int XLEN = 64;
  localparam int ILEN = 32;
  localparam logic [XLEN-1:0] BOOT_PC_DEFAULT = 64'h0;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic            taken;
    logic [XLEN-1:0] target;
  } prediction_t;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] target;
    logic            taken;
    logic            mispredict;
  } resolution_t;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] instr;
    logic            pred_taken;
    logic [XLEN-1:0] pred_target;
  } fetched_instr_t;

  function automatic logic [XLEN-1:0] next_seq(input logic [XLEN-1:0] pc);
    return pc + XLEN'(4);
  endfunction
endpackage

// File: rtl/fetch_buffer.sv
// In-order fetch buffer: entries are allocated at request time, filled by
// memory responses in order, and popped from the head once filled.
module fetch_buffer
  import fetch_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  clear_i,
  input  logic                  alloc_i,
  input  logic [XLEN-1:0]       alloc_pc_i,
  input  logic                  alloc_taken_i,
  input  logic [XLEN-1:0]       alloc_target_i,
  input  logic                  fill_i,
  input  logic [ILEN-1:0]       fill_instr_i,
  input  logic                  pop_i,
  output logic                  full_o,
  output logic [$clog2(DEPTH):0] unfilled_o,
  output logic                  head_vld_o,
  output fetched_instr_t        head_o
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [PW-1:0]    tail_q, tail_d, fill_q, fill_d, head_q, head_d;
  logic [CW-1:0]    count_q, count_d, unf_q, unf_d;
  logic [DEPTH-1:0] filled_q, filled_d;
  fetched_instr_t   ent_q [DEPTH];
  logic             alloc_ok, fill_ok, pop_ok;

  assign full_o     = (count_q == CW'(DEPTH));
  assign unfilled_o = unf_q;
  assign head_vld_o = filled_q[head_q];
  assign head_o     = ent_q[head_q];

  assign alloc_ok = alloc_i & ~full_o;
  assign fill_ok  = fill_i & (unf_q != '0);
  assign pop_ok   = pop_i & head_vld_o;

  always_comb begin
    tail_d   = tail_q;
    fill_d   = fill_q;
    head_d   = head_q;
    count_d  = count_q;
    unf_d    = unf_q;
    filled_d = filled_q;
    if (clear_i) begin
      tail_d   = '0;
      fill_d   = '0;
      head_d   = '0;
      count_d  = '0;
      unf_d    = '0;
      filled_d = '0;
    end else begin
      // Fill, pop and alloc always touch distinct slots, so their order is free.
      if (fill_ok) begin
        filled_d[fill_q] = 1'b1;
        fill_d           = fill_q + PW'(1);
      end
      if (pop_ok) begin
        filled_d[head_q] = 1'b0;
        head_d           = head_q + PW'(1);
      end
      if (alloc_ok) begin
        filled_d[tail_q] = 1'b0;
        tail_d           = tail_q + PW'(1);
      end
      count_d = count_q + CW'(alloc_ok) - CW'(pop_ok);
      unf_d   = unf_q + CW'(alloc_ok) - CW'(fill_ok);
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      tail_q   <= '0;
      fill_q   <= '0;
      head_q   <= '0;
      count_q  <= '0;
      unf_q    <= '0;
      filled_q <= '0;
    end else begin
      tail_q   <= tail_d;
      fill_q   <= fill_d;
      head_q   <= head_d;
      count_q  <= count_d;
      unf_q    <= unf_d;
      filled_q <= filled_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (alloc_ok) begin
      ent_q[tail_q].pc          <= alloc_pc_i;
      ent_q[tail_q].pred_taken  <= alloc_taken_i;
      ent_q[tail_q].pred_target <= alloc_target_i;
    end
    if (fill_ok) ent_q[fill_q].instr <= fill_instr_i;
  end
endmodule

// File: rtl/fetch_ctrl.sv
// Fetch controller: owns the PC and the count of stale responses still to be
// discarded after a flush or redirect; entry storage lives in fetch_buffer.
module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter int              DEPTH   = 2,
  parameter logic [XLEN-1:0] BOOT_PC = BOOT_PC_DEFAULT
) (
  input  logic            clk_i,
  input  logic            rst_n_i,
  input  logic            flush_i,
  output logic [XLEN-1:0] curr_pc_o,
  input  prediction_t     pred_i,
  input  logic            comm_res_valid_i,
  input  resolution_t     comm_res_i,
  output logic            mem_req_valid_o,
  input  logic            mem_req_ready_i,
  output logic [XLEN-1:0] mem_req_addr_o,
  input  logic            mem_ans_valid_i,
  input  logic [ILEN-1:0] mem_ans_instr_i,
  output logic            instr_valid_o,
  input  logic            instr_ready_i,
  output fetched_instr_t  instr_o
);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int DW = CW + 3;

  logic            redirect, kill, req_hs, fill, pop, full;
  logic [CW-1:0]   unfilled;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [DW-1:0]   drop_q, drop_d, drop_sum;
  logic            unused_pred_pc;

  assign unused_pred_pc = ^pred_i.pc;

  assign redirect        = comm_res_valid_i & comm_res_i.mispredict;
  assign kill            = redirect | flush_i;
  assign mem_req_valid_o = rst_n_i & ~full & ~kill;
  assign req_hs          = mem_req_valid_o & mem_req_ready_i;
  assign fill            = mem_ans_valid_i & (drop_q == '0) & ~kill;
  assign pop             = instr_valid_o & instr_ready_i;
  assign curr_pc_o       = pc_q;
  assign mem_req_addr_o  = pc_q;

  always_comb begin
    pc_d = pc_q;
    if (redirect)
      pc_d = comm_res_i.taken ? comm_res_i.target : next_seq(comm_res_i.pc);
    else if (req_hs)
      pc_d = pred_i.taken ? pred_i.target : next_seq(pc_q);
  end

  // A response arriving in the kill cycle is itself one of the stale ones.
  always_comb begin
    drop_sum = drop_q + DW'(unfilled);
    drop_d   = drop_q;
    if (kill)
      drop_d = drop_sum - DW'(mem_ans_valid_i && (drop_sum != '0));
    else if (mem_ans_valid_i && (drop_q != '0))
      drop_d = drop_q - DW'(1);
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      pc_q   <= BOOT_PC;
      drop_q <= '0;
    end else begin
      pc_q   <= pc_d;
      drop_q <= drop_d;
    end
  end

  fetch_buffer #(.DEPTH(DEPTH)) u_buf (
    .clk_i          (clk_i),
    .rst_n_i        (rst_n_i),
    .clear_i        (kill),
    .alloc_i        (req_hs),
    .alloc_pc_i     (pc_q),
    .alloc_taken_i  (pred_i.taken),
    .alloc_target_i (pred_i.target),
    .fill_i         (fill),
    .fill_instr_i   (mem_ans_instr_i),
    .pop_i          (pop),
    .full_o         (full),
    .unfilled_o     (unfilled),
    .head_vld_o     (instr_valid_o),
    .head_o         (instr_o)
  );

`ifndef SYNTHESIS
  always @(posedge clk_i) begin
    if (rst_n_i)
      assert (!(mem_ans_valid_i && (drop_q == '0) && (unfilled == '0)))
        else $error("fetch_ctrl: memory response with no outstanding request");
  end
`endif
endmodule

// File: tb/tb_fetch_ctrl.sv
// Self-checking bench for fetch_ctrl: queue-based reference model plus an
// in-order memory model, directed scenarios followed by randomized traffic.
module tb_fetch_ctrl;
  import fetch_pkg::*;

  localparam int              DEPTH = 2;
  localparam logic [XLEN-1:0] BOOT  = BOOT_PC_DEFAULT;

  logic            clk_i = 1'b0;
  logic            rst_n_i = 1'b1;
  logic            flush_i = 1'b0;
  logic [XLEN-1:0] curr_pc_o;
  prediction_t     pred_i = '0;
  logic            comm_res_valid_i = 1'b0;
  resolution_t     comm_res_i = '0;
  logic            mem_req_valid_o;
  logic            mem_req_ready_i = 1'b0;
  logic [XLEN-1:0] mem_req_addr_o;
  logic            mem_ans_valid_i = 1'b0;
  logic [ILEN-1:0] mem_ans_instr_i = '0;
  logic            instr_valid_o;
  logic            instr_ready_i = 1'b0;
  fetched_instr_t  instr_o;

  fetch_ctrl #(.DEPTH(DEPTH), .BOOT_PC(BOOT)) dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .flush_i(flush_i), .curr_pc_o(curr_pc_o),
    .pred_i(pred_i), .comm_res_valid_i(comm_res_valid_i), .comm_res_i(comm_res_i),
    .mem_req_valid_o(mem_req_valid_o), .mem_req_ready_i(mem_req_ready_i),
    .mem_req_addr_o(mem_req_addr_o), .mem_ans_valid_i(mem_ans_valid_i),
    .mem_ans_instr_i(mem_ans_instr_i), .instr_valid_o(instr_valid_o),
    .instr_ready_i(instr_ready_i), .instr_o(instr_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic           req_v;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] addr;
    logic           out_v;
    fetched_instr_t ins;
  } obs_t;

  typedef struct {
    logic [XLEN-1:0] pc;
    logic            taken;
    logic [XLEN-1:0] target;
    logic            filled;
    logic [ILEN-1:0] instr;
  } ent_t;

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  // reference model state
  ent_t            m_q[$];
  logic [XLEN-1:0] m_pc = '0;
  int              m_drop = 0;

  // memory model and predictor policy
  logic [XLEN-1:0] mem_addr_q[$];
  int              mem_due_q[$];
  int              lat = 1;
  bit              lat_rand = 0;
  logic [XLEN-1:0] pt_pc = '1;
  logic [XLEN-1:0] pt_target = '0;
  bit              pt_rand = 0;

  logic [XLEN-1:0] rq_addr[$];
  int              rq_cyc[$];
  fetched_instr_t  op[$];
  int              op_cyc[$];

  function automatic logic [ILEN-1:0] instr_of(input logic [XLEN-1:0] a);
    return (a[31:0] * 32'h9E3779B1) ^ 32'h0000_0013;
  endfunction

  function automatic logic [XLEN-1:0] rnd_addr();
    return {52'h0, 10'($urandom_range(0, 1023)), 2'b00};
  endfunction

  function automatic obs_t dut_obs();
    obs_t o;
    o = '0;
    o.req_v = mem_req_valid_o;
    o.pc    = curr_pc_o;
    o.addr  = mem_req_addr_o;
    o.out_v = instr_valid_o;
    if (instr_valid_o) o.ins = instr_o;
    return o;
  endfunction

  function automatic obs_t model_obs();
    obs_t o;
    o = '0;
    o.req_v = (m_q.size() < DEPTH) && !flush_i && !(comm_res_valid_i && comm_res_i.mispredict);
    o.pc    = m_pc;
    o.addr  = m_pc;
    if (m_q.size() > 0 && m_q[0].filled) begin
      o.out_v = 1'b1;
      o.ins   = '{pc: m_q[0].pc, instr: m_q[0].instr,
                  pred_taken: m_q[0].taken, pred_target: m_q[0].target};
    end
    return o;
  endfunction

  task automatic model_update();
    bit redir, kill, req_v, hs, pop, done;
    int u;
    ent_t e;
    redir = comm_res_valid_i && comm_res_i.mispredict;
    kill  = redir || flush_i;
    req_v = (m_q.size() < DEPTH) && !kill;
    hs    = req_v && mem_req_ready_i;
    pop   = (m_q.size() > 0) && m_q[0].filled && instr_ready_i;
    u = 0;
    foreach (m_q[i]) if (!m_q[i].filled) u++;
    if (kill) begin
      m_drop = m_drop + u - ((mem_ans_valid_i && (m_drop + u) > 0) ? 1 : 0);
      m_q.delete();
    end else begin
      if (mem_ans_valid_i) begin
        if (m_drop > 0) m_drop--;
        else begin
          done = 0;
          foreach (m_q[i]) if (!done && !m_q[i].filled) begin
            e = m_q[i]; e.filled = 1'b1; e.instr = mem_ans_instr_i; m_q[i] = e; done = 1;
          end
        end
      end
      if (pop) void'(m_q.pop_front());
      if (hs) m_q.push_back('{pc: m_pc, taken: pred_i.taken, target: pred_i.target,
                              filled: 1'b0, instr: '0});
    end
    if (redir) m_pc = comm_res_i.taken ? comm_res_i.target : comm_res_i.pc + 64'd4;
    else if (hs) m_pc = pred_i.taken ? pred_i.target : m_pc + 64'd4;
  endtask

  task automatic drive_env();
    pred_i.pc = m_pc;
    if (pt_rand) begin
      pred_i.taken  = ($urandom_range(0, 3) == 0);
      pred_i.target = rnd_addr();
    end else begin
      pred_i.taken  = (m_pc == pt_pc);
      pred_i.target = pt_target;
    end
    mem_ans_valid_i = 1'b0;
    mem_ans_instr_i = '0;
    if (mem_addr_q.size() > 0 && mem_due_q[0] <= cyc) begin
      mem_ans_valid_i = 1'b1;
      mem_ans_instr_i = instr_of(mem_addr_q[0]);
    end
  endtask

  task automatic tick();
    int l, d;
    model_update();
    if (mem_ans_valid_i) begin
      void'(mem_addr_q.pop_front());
      void'(mem_due_q.pop_front());
    end
    if (mem_req_valid_o && mem_req_ready_i) begin
      l = lat_rand ? int'($urandom_range(1, 3)) : lat;
      d = cyc + l;
      if (mem_due_q.size() > 0 && mem_due_q[$] + 1 > d) d = mem_due_q[$] + 1;
      mem_addr_q.push_back(mem_req_addr_o);
      mem_due_q.push_back(d);
    end
    @(posedge clk_i); #1;
    cyc++;
  endtask

  task automatic do_reset();
    rst_n_i = 1'b0;
    flush_i = 1'b0; comm_res_valid_i = 1'b0; comm_res_i = '0; pred_i = '0;
    mem_req_ready_i = 1'b1; instr_ready_i = 1'b1;
    mem_ans_valid_i = 1'b0; mem_ans_instr_i = '0;
    pt_pc = '1; pt_target = '0; pt_rand = 0; lat = 1; lat_rand = 0;
    mem_addr_q.delete(); mem_due_q.delete();
    m_q.delete(); m_pc = BOOT; m_drop = 0;
    rq_addr.delete(); rq_cyc.delete(); op.delete(); op_cyc.delete();
    repeat (2) @(posedge clk_i);
    #1 rst_n_i = 1'b1;
    cyc = 0;
  endtask

  task automatic test_reset();
    obs_t od, om;
    #1 rst_n_i = 1'b0;
    #1;
    tests++; if (instr_valid_o !== 1'b0) begin fails++; $display("FAIL rst_instr_valid got %b want 0", instr_valid_o); end
    tests++; if (mem_req_valid_o !== 1'b0) begin fails++; $display("FAIL rst_req_valid got %b want 0", mem_req_valid_o); end
    tests++; if (curr_pc_o !== BOOT) begin fails++; $display("FAIL rst_pc got %h want %h", curr_pc_o, BOOT); end
    do_reset();
    drive_env(); #1;
    tests++; if (mem_req_valid_o !== 1'b1) begin fails++; $display("FAIL rst_first_req got %b want 1", mem_req_valid_o); end
    tests++; od = dut_obs(); om = model_obs();
    if (od !== om) begin fails++; $display("FAIL rst_cycle got %h want %h", od, om); end
    tick();
  endtask

  task automatic test_sequential();
    obs_t od, om;
    do_reset();
    for (int c = 0; c < 10; c++) begin
      drive_env(); #1;
      tests++; od = dut_obs(); om = model_obs();
      if (od !== om) begin fails++; $display("FAIL seq_cycle%0d got %h want %h", cyc, od, om); end
      if (mem_req_valid_o && mem_req_ready_i) begin rq_addr.push_back(mem_req_addr_o); rq_cyc.push_back(cyc); end
      if (instr_valid_o && instr_ready_i) begin op.push_back(instr_o); op_cyc.push_back(cyc); end
      tick();
    end
    for (int k = 0; k < 3; k++) begin
      tests++;
      if (rq_addr.size() <= k || op.size() <= k) begin
        fails++; $display("FAIL seq_count%0d got req=%0d out=%0d want >%0d", k, rq_addr.size(), op.size(), k);
      end else if ({rq_addr[k], op[k].pc, op_cyc[k]} !== {64'(4*k), 64'(4*k), rq_cyc[k] + 2}) begin
        fails++;
        $display("FAIL seq_order%0d got req=%h out=%h@%0d want %h@%0d", k, rq_addr[k], op[k].pc,
                 op_cyc[k], 64'(4*k), rq_cyc[k] + 2);
      end
    end
  endtask

  task automatic test_taken();
    obs_t od, om;
    int idx;
    logic [XLEN-1:0] nxt;
    logic [XLEN:0] tag;
    do_reset();
    pt_pc = 64'h8; pt_target = 64'h100;
    for (int c = 0; c < 12; c++) begin
      drive_env(); #1;
      tests++; od = dut_obs(); om = model_obs();
      if (od !== om) begin fails++; $display("FAIL taken_cycle%0d got %h want %h", cyc, od, om); end
      if (mem_req_valid_o && mem_req_ready_i) rq_addr.push_back(mem_req_addr_o);
      if (instr_valid_o && instr_ready_i) op.push_back(instr_o);
      tick();
    end
    idx = -1;
    foreach (rq_addr[i]) if (idx < 0 && rq_addr[i] == 64'h8) idx = i;
    nxt = (idx >= 0 && idx + 1 < rq_addr.size()) ? rq_addr[idx+1] : '1;
    tests++; if (nxt !== 64'h100) begin fails++; $display("FAIL taken_next_req got %h want 100", nxt); end
    tag = '1;
    foreach (op[i]) if (op[i].pc == 64'h8) tag = {op[i].pred_taken, op[i].pred_target};
    tests++; if (tag !== {1'b1, 64'h100}) begin fails++; $display("FAIL taken_tag got %h want %h", tag, {1'b1, 64'h100}); end
  endtask

  task automatic test_stall();
    obs_t od, om;
    int nreq;
    bit have;
    fetched_instr_t held;
    do_reset();
    nreq = 0; have = 0; held = '0;
    for (int c = 0; c < 8; c++) begin
      drive_env(); instr_ready_i = 1'b0; #1;
      tests++; od = dut_obs(); om = model_obs();
      if (od !== om) begin fails++; $display("FAIL stall_cycle%0d got %h want %h", cyc, od, om); end
      if (mem_req_valid_o && mem_req_ready_i) nreq++;
      if (instr_valid_o) begin
        if (!have) begin held = instr_o; have = 1; end
        else begin
          tests++;
          if (instr_o !== held) begin fails++; $display("FAIL stall_hold got %h want %h", instr_o, held); end
        end
      end
      tick();
    end
    tests++; if (nreq != 2) begin fails++; $display("FAIL stall_nreq got %0d want 2", nreq); end
    tests++; if (mem_req_valid_o !== 1'b0) begin fails++; $display("FAIL stall_blocked got %b want 0", mem_req_valid_o); end
    drive_env(); instr_ready_i = 1'b1; #1;
    tests++;
    if ({instr_valid_o, mem_req_valid_o} !== 2'b10) begin
      fails++; $display("FAIL stall_pop_cycle got valid=%b req=%b want 1 0", instr_valid_o, mem_req_valid_o);
    end
    tick();
    drive_env(); #1;
    tests++; if (mem_req_valid_o !== 1'b1) begin fails++; $display("FAIL stall_reopen got %b want 1", mem_req_valid_o); end
    tests++; od = dut_obs(); om = model_obs();
    if (od !== om) begin fails++; $display("FAIL stall_reopen_cycle got %h want %h", od, om); end
    tick();
  endtask

  task automatic test_redirect();
    obs_t od, om;
    bit seen;
    logic [XLEN+ILEN-1:0] first;
    do_reset();
    lat = 3; seen = 0; first = '1;
    for (int c = 0; c < 14; c++) begin
      drive_env();
      comm_res_valid_i = (cyc == 2);
      comm_res_i = '{pc: 64'h40, target: 64'h200, taken: 1'b1, mispredict: 1'b1};
      #1;
      tests++; od = dut_obs(); om = model_obs();
      if (od !== om) begin fails++; $display("FAIL redir_cycle%0d got %h want %h", cyc, od, om); end
      if (instr_valid_o && !seen) begin seen = 1; first = {instr_o.pc, instr_o.instr}; end
      tick();
    end
    comm_res_valid_i = 1'b0;
    tests++;
    if (first !== {64'h200, instr_of(64'h200)}) begin
      fails++; $display("FAIL redir_first_out got %h want %h", first, {64'h200, instr_of(64'h200)});
    end
  endtask

  task automatic test_redirect_resp();
    obs_t od, om;
    bit seen;
    logic [XLEN+ILEN-1:0] first;
    do_reset();
    lat = 2; seen = 0; first = '1;
    for (int c = 0; c < 12; c++) begin
      drive_env();
      comm_res_valid_i = (cyc == 2);
      comm_res_i = '{pc: 64'h40, target: 64'h999, taken: 1'b0, mispredict: 1'b1};
      #1;
      tests++; od = dut_obs(); om = model_obs();
      if (od !== om) begin fails++; $display("FAIL rresp_cycle%0d got %h want %h", cyc, od, om); end
      if (cyc == 3) begin
        tests++;
        if ({curr_pc_o, instr_valid_o} !== {64'h44, 1'b0}) begin
          fails++; $display("FAIL rresp_after got pc=%h valid=%b want 44 0", curr_pc_o, instr_valid_o);
        end
      end
      if (instr_valid_o && !seen) begin seen = 1; first = {instr_o.pc, instr_o.instr}; end
      tick();
    end
    comm_res_valid_i = 1'b0;
    tests++;
    if (first !== {64'h44, instr_of(64'h44)}) begin
      fails++; $display("FAIL rresp_first_out got %h want %h", first, {64'h44, instr_of(64'h44)});
    end
  endtask

  task automatic test_reset_midop();
    obs_t od, om;
    do_reset();
    for (int c = 0; c < 6; c++) begin
      drive_env(); instr_ready_i = 1'b0; #1;
      tests++; od = dut_obs(); om = model_obs();
      if (od !== om) begin fails++; $display("FAIL midrst_cycle%0d got %h want %h", cyc, od, om); end
      tick();
    end
    tests++; if (instr_valid_o !== 1'b1) begin fails++; $display("FAIL midrst_pre got %b want 1", instr_valid_o); end
    #3 rst_n_i = 1'b0;
    #1;
    tests++; if (instr_valid_o !== 1'b0) begin fails++; $display("FAIL midrst_async got %b want 0", instr_valid_o); end
    tests++; if (mem_req_valid_o !== 1'b0) begin fails++; $display("FAIL midrst_req got %b want 0", mem_req_valid_o); end
    do_reset();
    drive_env(); #1;
    tests++;
    if ({mem_req_valid_o, mem_req_addr_o} !== {1'b1, BOOT}) begin
      fails++; $display("FAIL midrst_first_req got %b %h want 1 %h", mem_req_valid_o, mem_req_addr_o, BOOT);
    end
    tick();
  endtask

  task automatic test_random();
    obs_t od, om;
    do_reset();
    pt_rand = 1; lat_rand = 1;
    for (int c = 0; c < 3000; c++) begin
      drive_env();
      flush_i          = ($urandom_range(0, 24) == 0);
      comm_res_valid_i = ($urandom_range(0, 19) == 0);
      comm_res_i = '{pc: rnd_addr(), target: rnd_addr(), taken: 1'($urandom_range(0, 1)),
                     mispredict: 1'($urandom_range(0, 1))};
      mem_req_ready_i  = ($urandom_range(0, 3) != 0);
      instr_ready_i    = ($urandom_range(0, 2) != 0);
      #1;
      tests++; od = dut_obs(); om = model_obs();
      if (od !== om) begin fails++; $display("FAIL rand_cycle%0d got %h want %h", cyc, od, om); end
      tick();
      if (fails > 20) break;
    end
    flush_i = 1'b0; comm_res_valid_i = 1'b0;
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_taken();
    test_stall();
    test_redirect();
    test_redirect_resp();
    test_reset_midop();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout got no finish want finish");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/fetch_ctrl.md
FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 Parameter DEPTH, default 2: fetch-buffer entries, which also bounds requests in flight; power of two, at least 2.
REQ-002 Parameter BOOT_PC, default 64'h0: PC loaded at reset.
REQ-003 clk_i  in  1  single clock for the block.
REQ-004 rst_n_i  in  1  reset, asynchronous, active-low.
REQ-005 flush_i  in  1  discard all buffered and in-flight fetches.
REQ-006 curr_pc_o  out  XLEN  current fetch PC, driven to the branch predictor.
REQ-007 pred_i  in  prediction_t  predictor result {pc, taken, target} for curr_pc_o, same cycle.
REQ-008 comm_res_valid_i  in  1  commit resolution is valid.
REQ-009 comm_res_i  in  resolution_t  commit resolution {pc, target, taken, mispredict}.
REQ-010 mem_req_valid_o / mem_req_ready_i / mem_req_addr_o  out/in/out  1/1/XLEN  instruction-memory request handshake.
REQ-011 mem_ans_valid_i / mem_ans_instr_i  in/in  1/ILEN  in-order memory response; no backpressure.
REQ-012 instr_valid_o / instr_ready_i / instr_o  out/in/fetched_instr_t  handshake to the issue queue; instr_o carries {pc, instr, pred_taken, pred_target}.

Function
REQ-013 Redirect SHALL be defined as comm_res_valid_i & comm_res_i.mispredict.
REQ-014 The PC register SHALL update as follows, in priority order:
- On redirect: comm_res_i.target if comm_res_i.taken, otherwise comm_res_i.pc+4.
- On a request handshake: pred_i.target if pred_i.taken, otherwise PC+4.
- Otherwise: hold.
REQ-015 curr_pc_o and mem_req_addr_o SHALL equal the PC register.
REQ-016 mem_req_valid_o SHALL be 1 iff the buffer is not full (registered count < DEPTH) and neither redirect nor flush_i is asserted in that cycle.
REQ-017 A request handshake SHALL allocate the tail entry with {PC, pred_i.taken, pred_i.target} and filled=0.
REQ-018 A response with drop_cnt==0 SHALL write mem_ans_instr_i into the oldest unfilled entry and set filled=1.
REQ-019 instr_valid_o SHALL be the registered filled bit of the head entry. Minimum latency is response cycle t -> instr_valid_o at t+1.
REQ-020 Handshake at the output (instr_valid_o & instr_ready_i) SHALL pop the head entry.
REQ-021 instr_o SHALL hold steady while instr_valid_o=1 and instr_ready_i=0.
REQ-022 Allocation, fill and pop SHALL all be allowed in the same cycle.
REQ-023 Full SHALL be computed from the registered count only; there is no same-cycle pop bypass.
REQ-024 Tail, fill and head pointers SHALL wrap modulo DEPTH.
REQ-025 On flush_i or redirect:
- All entries SHALL be invalidated and all pointers zeroed next cycle.
- drop_cnt_next = drop_cnt + (allocated-unfilled count) - (mem_ans_valid_i ? 1 : 0).
REQ-026 A response arriving while drop_cnt>0 SHALL be discarded and SHALL decrement drop_cnt.
REQ-027 New requests SHALL be allowed during dropping. Dropped responses always precede new ones, so in-order pairing holds.
REQ-028 flush_i without redirect SHALL leave the PC unchanged.
REQ-029 A response with no unfilled entry and drop_cnt==0 is a protocol error. It SHALL be ignored and flagged by a simulation assertion.

Reset
REQ-030 Asynchronous reset SHALL set PC=BOOT_PC, all pointers, count and drop_cnt=0, and all valid/filled bits=0.
REQ-031 Output values during reset: instr_valid_o=0, mem_req_valid_o=0, curr_pc_o=BOOT_PC.
REQ-032 mem_req_valid_o SHALL be 1 in the first cycle after reset release.
REQ-033 Reset asserted mid-operation SHALL abandon in-flight responses without a drop count. The memory side is reset by the same signal.

Structure
REQ-034 fetched_instr_t, ILEN and BOOT_PC defaults SHALL live in fetch_pkg. prediction_t and resolution_t are reused from fetch_pkg unchanged.
REQ-035 The entry storage SHALL be one sub-module, fetch_buffer, holding the tail, fill and head pointers, the count, and the filled bits. fetch_ctrl holds the PC and drop_cnt.

Verification
REQ-036 Reset, then pred_i.taken=0, memory answering 1 cycle after each request, instr_ready_i=1 -> requests at 0x0, 0x4, 0x8. instr_o.pc follows the same sequence, each 2 cycles after its request.
REQ-037 pred_i.taken=1, target=0x100, at PC 0x8 -> next request address is 0x100. The entry for 0x8 carries pred_taken=1, pred_target=0x100.
REQ-038 instr_ready_i=0 with DEPTH=2 -> exactly 2 requests issued, then mem_req_valid_o=0. instr_o is stable. Raising instr_ready_i reopens requests one cycle after the first pop.
REQ-039 Two requests outstanding, then redirect with comm_res_i {pc=0x40, taken=1, target=0x200} -> next two responses discarded. No instr_valid_o until the response for 0x200, which is tagged pc=0x200.
REQ-040 Redirect with taken=0, pc=0x40, in the same cycle as a response -> PC=0x44, drop_cnt = outstanding-1, and that response is not written.
REQ-041 rst_n_i asserted with a full buffer -> instr_valid_o=0 immediately (asynchronous). After release, the first request address is BOOT_PC.
